memory_sequence_engine: RTL and testbench

Consumer end of the LFSR random-number interface. It requests one random symbol per round from the LFSR generator, appends it to a stored sequence, and replays the whole sequence to the display. It then checks the player's button entries against the stored sequence. It sits between the RNG and the LED/button logic of the memory game and owns round progression and win/lose outcome.

---
 rtl/memory_game_pkg.sv | 19 +
 rtl/memory_sequence_buffer.sv | 26 ++
 rtl/memory_sequence_engine.sv | 147 ++++++++++++++
 tb/tb_memory_sequence_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// Shared constants for the memory game: symbol width, default game timing
// and the 3-bit FSM state encoding used by the sequence engine.
package memory_game_pkg;

  localparam int SYMBOL_W = 4;

  localparam int DEFAULT_MAX_LEN     = 16;
  localparam int DEFAULT_SHOW_CYCLES = 4;
  localparam int DEFAULT_GAP_CYCLES  = 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CAPTURE    = 3'd1;
  localparam logic [2:0] ST_SHOW       = 3'd2;
  localparam logic [2:0] ST_GAP        = 3'd3;
  localparam logic [2:0] ST_WAIT_INPUT = 3'd4;
  localparam logic [2:0] ST_WIN        = 3'd5;
  localparam logic [2:0] ST_LOSE       = 3'd6;

endpackage

// File: rtl/memory_sequence_buffer.sv
// Stored symbol sequence: one synchronous write port, one combinational read
// port. Storage is deliberately left unreset; only entries below len are read.
module memory_sequence_buffer
  import memory_game_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_LEN
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [SYMBOL_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [SYMBOL_W-1:0]        rd_data
);

  logic [SYMBOL_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/memory_sequence_engine.sv
// Memory game sequencer: grows a random symbol sequence one round at a time,
// replays it to the display and checks the player's entries against it.
module memory_sequence_engine
  import memory_game_pkg::*;
#(
  parameter int MAX_LEN     = DEFAULT_MAX_LEN,
  parameter int SHOW_CYCLES = DEFAULT_SHOW_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SYMBOL_W-1:0] rng_q,
  output logic                rng_enable,
  input  logic                player_valid,
  input  logic [SYMBOL_W-1:0] player_value,
  output logic                show_valid,
  output logic [SYMBOL_W-1:0] show_value,
  output logic                busy,
  output logic [4:0]          level,
  output logic                win,
  output logic                lose
);

  localparam int ADDR_W   = $clog2(MAX_LEN);
  localparam int HOLD_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;
  localparam logic [HOLD_W-1:0] SHOW_LAST = HOLD_W'(SHOW_CYCLES - 1);
  localparam logic [HOLD_W-1:0] GAP_LAST  = HOLD_W'(GAP_CYCLES - 1);
  localparam logic [4:0]        LEN_MAX   = 5'(MAX_LEN);

  logic [2:0]          state_reg, state_next;
  logic [4:0]          len_reg, len_next;
  logic [ADDR_W-1:0]   idx_reg, idx_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic                win_reg, win_next;
  logic                lose_reg, lose_next;
  logic [ADDR_W-1:0]   last_idx;
  logic [SYMBOL_W-1:0] rd_data;
  logic                capture;

  assign capture  = (state_reg == ST_CAPTURE);
  // New symbol goes to slot len-1, which is also the final replay/check index.
  assign last_idx = ADDR_W'(len_reg - 5'd1);

  memory_sequence_buffer #(
    .DEPTH (MAX_LEN)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (capture),
    .wr_addr (last_idx),
    .wr_data (rng_q),
    .rd_addr (idx_reg),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    hold_next  = hold_reg;
    win_next   = win_reg;
    lose_next  = lose_reg;
    case (state_reg)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          len_next   = 5'd1;
          win_next   = 1'b0;
          lose_next  = 1'b0;
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        idx_next   = '0;
        hold_next  = '0;
        state_next = ST_SHOW;
      end
      ST_SHOW: begin
        if (hold_reg == SHOW_LAST) begin
          hold_next  = '0;
          state_next = ST_GAP;
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      ST_GAP: begin
        if (hold_reg == GAP_LAST) begin
          hold_next = '0;
          if (idx_reg == last_idx) begin
            idx_next   = '0;
            state_next = ST_WAIT_INPUT;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ST_SHOW;
          end
        end else begin
          hold_next = hold_reg + 1'b1;
        end
      end
      ST_WAIT_INPUT: begin
        if (player_valid) begin
          if (player_value != rd_data) begin
            lose_next  = 1'b1;
            state_next = ST_LOSE;
          end else if (idx_reg != last_idx) begin
            idx_next = idx_reg + 1'b1;
          end else if (len_reg == LEN_MAX) begin
            win_next   = 1'b1;
            state_next = ST_WIN;
          end else begin
            len_next   = len_reg + 5'd1;
            state_next = ST_CAPTURE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
      hold_reg  <= '0;
      win_reg   <= 1'b0;
      lose_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      hold_reg  <= hold_next;
      win_reg   <= win_next;
      lose_reg  <= lose_next;
    end
  end

  assign rng_enable = capture;
  assign show_valid = (state_reg == ST_SHOW);
  assign show_value = show_valid ? rd_data : '0;
  assign busy       = capture || (state_reg == ST_SHOW) || (state_reg == ST_GAP) ||
                      (state_reg == ST_WAIT_INPUT);
  assign level      = len_reg;
  assign win        = win_reg;
  assign lose       = lose_reg;

endmodule

// File: tb/tb_memory_sequence_engine.sv
// Self-checking bench: stub RNG table, a queue-based model of the expected
// sequence, directed games from the test plan followed by randomized games.
module tb_memory_sequence_engine;

  localparam int MAX_LEN     = 4;
  localparam int SHOW_CYCLES = 2;
  localparam int GAP_CYCLES  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] rng_q;
  logic       rng_enable;
  logic       player_valid = 1'b0;
  logic [3:0] player_value = 4'h0;
  logic       show_valid;
  logic [3:0] show_value;
  logic       busy;
  logic [4:0] level;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;

  logic [3:0] rng_table [64];
  logic [5:0] rng_ptr = 6'd0;
  logic [5:0] exp_ptr = 6'd0;
  int         rng_pulses = 0;
  int         exp_pulses = 0;
  logic [3:0] seq_q [$];

  memory_sequence_engine #(
    .MAX_LEN     (MAX_LEN),
    .SHOW_CYCLES (SHOW_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rng_q        (rng_q),
    .rng_enable   (rng_enable),
    .player_valid (player_valid),
    .player_value (player_value),
    .show_valid   (show_valid),
    .show_value   (show_value),
    .busy         (busy),
    .level        (level),
    .win          (win),
    .lose         (lose)
  );

  always #5 clk = ~clk;

  // Stub RNG: presents the next table entry, advances on each enable pulse.
  assign rng_q = rng_table[rng_ptr];
  always @(posedge clk) begin
    if (rng_enable === 1'b1) begin
      rng_ptr    <= rng_ptr + 6'd1;
      rng_pulses <= rng_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input int exp_level, input int exp_win,
                             input int exp_lose);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rng_enable"}, 32'(rng_enable), 0);
    check({tag, "_show_valid"}, 32'(show_valid), 0);
    check({tag, "_show_value"}, 32'(show_value), 0);
    check({tag, "_level"}, 32'(level), exp_level);
    check({tag, "_win"}, 32'(win), exp_win);
    check({tag, "_lose"}, 32'(lose), exp_lose);
  endtask

  // Entered at the negedge of the CAPTURE cycle; leaves at the first WAIT_INPUT cycle.
  task automatic play_round(input int n, input bit noise);
    check("cap_rng_enable", 32'(rng_enable), 1);
    check("cap_busy", 32'(busy), 1);
    check("cap_level", 32'(level), n);
    check("cap_show_valid", 32'(show_valid), 0);
    check("cap_win", 32'(win), 0);
    check("cap_lose", 32'(lose), 0);
    seq_q.push_back(rng_table[exp_ptr]);
    exp_ptr = exp_ptr + 6'd1;
    exp_pulses++;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < SHOW_CYCLES; c++) begin
        @(negedge clk);
        player_valid = 1'b0;
        start = 1'b0;
        check("show_valid", 32'(show_valid), 1);
        check("show_value", 32'(show_value), 32'(seq_q[i]));
        check("show_rng_idle", 32'(rng_enable), 0);
        check("show_level", 32'(level), n);
        if (noise && c == 0) begin
          player_valid = 1'b1;
          player_value = 4'h7;
          start = (i == 0);
        end
      end
      for (int g = 0; g < GAP_CYCLES; g++) begin
        @(negedge clk);
        player_valid = 1'b0;
        start = 1'b0;
        check("gap_valid", 32'(show_valid), 0);
        check("gap_value", 32'(show_value), 0);
        check("gap_busy", 32'(busy), 1);
      end
    end
    @(negedge clk);
    check("wait_busy", 32'(busy), 1);
    check("wait_show_valid", 32'(show_valid), 0);
    check("wait_level", 32'(level), n);
  endtask

  task automatic enter(input logic [3:0] v);
    player_valid = 1'b1;
    player_value = v;
    @(negedge clk);
    player_valid = 1'b0;
  endtask

  // fail_round 0 = play perfectly; abort_round 0 = no mid-game reset.
  task automatic play_game(input int fail_round, input int fail_pos, input logic [3:0] fail_mask,
                           input int abort_round, input bit noise);
    seq_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 1; r <= MAX_LEN; r++) begin
      play_round(r, noise);
      if (r == abort_round) begin
        #2 rst = 1'b0;
        #1;
        check_quiet("async_reset", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_quiet("in_reset", 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("after_reset", 0, 0, 0);
        check("reset_rng_count", 32'(rng_pulses), 32'(exp_pulses));
        return;
      end
      for (int p = 0; p < r; p++) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check("wait_hold_busy", 32'(busy), 1);
        end
        if (r == fail_round && p == fail_pos) begin
          enter(seq_q[p] ^ fail_mask);
          check_quiet("lose", r, 0, 1);
          repeat (3) @(negedge clk);
          check_quiet("lose_sticky", r, 0, 1);
          check("lose_rng_count", 32'(rng_pulses), 32'(exp_pulses));
          return;
        end
        enter(seq_q[p]);
        if (p < r - 1) begin
          check("entry_wait_busy", 32'(busy), 1);
          check("entry_wait_rng", 32'(rng_enable), 0);
        end
      end
    end
    check_quiet("win", MAX_LEN, 1, 0);
    repeat (3) @(negedge clk);
    check_quiet("win_sticky", MAX_LEN, 1, 0);
    check("win_rng_count", 32'(rng_pulses), 32'(exp_pulses));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] base [4];
    base[0] = 4'h3;
    base[1] = 4'hA;
    base[2] = 4'h5;
    base[3] = 4'hC;
    for (int i = 0; i < 64; i++) begin
      rng_table[i] = (i < 16) ? base[i % 4] : 4'($urandom_range(0, 15));
    end
    rng_table[16] = 4'h0;

    #1 rst = 1'b0;
    #1;
    check_quiet("reset", 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("idle", 0, 0, 0);

    // Perfect game: 3; 3,A; 3,A,5; 3,A,5,C.
    play_game(0, 0, 4'h0, 0, 1'b0);
    // Round 2, entries 3 then 5 (A^F = 5).
    play_game(2, 1, 4'hF, 0, 1'b0);
    // Noise during replay, then reset in WAIT_INPUT at level 3.
    play_game(0, 0, 4'h0, 3, 1'b1);
    // Restart after reset clears everything and still wins.
    play_game(0, 0, 4'h0, 0, 1'b1);

    for (int g = 0; g < 6; g++) begin
      int fr;
      int fp;
      fr = $urandom_range(0, MAX_LEN);
      fp = (fr > 0) ? $urandom_range(0, fr - 1) : 0;
      play_game(fr, fp, 4'($urandom_range(1, 15)), 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
